// File: rtl/traffic_lamp_driver.sv
// ============================================================================
// traffic_lamp_driver
// ----------------------------------------------------------------------------
// Consumer end of the 3-bit traffic-code interface. Registers the four light
// codes from the intersection controller and drives discrete lamp enables for
// the car and walker heads. It also generates the twinkle/flash blink. A
// safety monitor forces a latched flashing-yellow fail-safe state whenever the
// registered codes conflict or contain an illegal value.
//
// Parameters
//   BLINK_HALF      clk cycles per blink half-period (>=2), twinkle and flash
//   STARTUP_CYCLES  all-red cycles after reset or fault clear (>=1)
//
// Ports
//   clk             in   1  system clock, rising edge
//   reset           in   1  asynchronous, active-high reset
//   h_car_code      in   3  000 RED, 001 GREEN, 010 YELLOW, 011 LEFT
//   v_car_code      in   3  same encoding as h_car_code
//   h_walker_code   in   3  000 RED, 001 GREEN, 100 GREEN_TWINKLE
//   v_walker_code   in   3  same encoding as h_walker_code
//   fault_clr       in   1  request exit from FAILSAFE
//   h_car_lamp      out  4  {left, green, yellow, red}
//   v_car_lamp      out  4  {left, green, yellow, red}
//   h_walker_lamp   out  2  {green, red}
//   v_walker_lamp   out  2  {green, red}
//   fault           out  1  high while in FAILSAFE
//   fault_count     out  8  FAILSAFE entries, saturating (FAULT_COUNT_EN only)
//
// Build option
//   FAULT_COUNT_EN  when defined, adds the fault_count output and its counter
// ============================================================================
module traffic_lamp_driver #(
    parameter int unsigned BLINK_HALF     = 4,
    parameter int unsigned STARTUP_CYCLES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] h_car_code,
    input  logic [2:0] v_car_code,
    input  logic [2:0] h_walker_code,
    input  logic [2:0] v_walker_code,
    input  logic       fault_clr,
    output logic [3:0] h_car_lamp,
    output logic [3:0] v_car_lamp,
    output logic [1:0] h_walker_lamp,
    output logic [1:0] v_walker_lamp,
    output logic       fault
`ifdef FAULT_COUNT_EN
    ,
    output logic [7:0] fault_count
`endif
);

    localparam int unsigned BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int unsigned SW = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;

    localparam logic [2:0] CODE_RED   = 3'b000;
    localparam logic [2:0] CODE_GREEN = 3'b001;
    localparam logic [2:0] CAR_YELLOW = 3'b010;
    localparam logic [2:0] CAR_LEFT   = 3'b011;
    localparam logic [2:0] WALK_TWINK = 3'b100;

    typedef enum logic [1:0] {
        ST_STARTUP  = 2'd0,
        ST_NORMAL   = 2'd1,
        ST_FAILSAFE = 2'd2
    } state_e;

    function automatic logic [3:0] car_decode(input logic [2:0] code);
        case (code)
            CODE_GREEN: return 4'b0100;
            CAR_YELLOW: return 4'b0010;
            CAR_LEFT:   return 4'b1001;
            default:    return 4'b0001;
        endcase
    endfunction

    function automatic logic [1:0] walker_decode(input logic [2:0] code, input logic phase);
        case (code)
            CODE_GREEN: return 2'b10;
            WALK_TWINK: return {phase, 1'b0};
            default:    return 2'b01;
        endcase
    endfunction

    function automatic logic walker_legal(input logic [2:0] code);
        return (code == CODE_RED) || (code == CODE_GREEN) || (code == WALK_TWINK);
    endfunction

    state_e          state_q, state_d;
    logic [SW-1:0]   startup_cnt_q, startup_cnt_d;
    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic            phase_q, phase_d;
    logic [2:0]      h_car_q, v_car_q, h_walk_q, v_walk_q;
    logic [3:0]      h_car_lamp_d, v_car_lamp_d;
    logic [1:0]      h_walker_lamp_d, v_walker_lamp_d;
    logic            fault_d;
    logic            conflict;
`ifdef FAULT_COUNT_EN
    logic [7:0]      fault_count_d;
`endif

    // Conflict is judged on the registered codes, the same values the lamp
    // decode sees, so a bad combination is caught before it can be displayed.
    always_comb begin
        conflict = ((h_car_q != CODE_RED) && (v_car_q != CODE_RED))
                || ((h_walk_q != CODE_RED) && (h_car_q != CODE_RED))
                || ((v_walk_q != CODE_RED) && (v_car_q != CODE_RED))
                || h_car_q[2] || v_car_q[2]
                || !walker_legal(h_walk_q) || !walker_legal(v_walk_q);
    end

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        // Free-running blink; phase flips as the counter wraps.
        blink_cnt_d = blink_cnt_q + BW'(1);
        phase_d     = phase_q;
        if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end

        state_d       = state_q;
        startup_cnt_d = '0;
        case (state_q)
            ST_STARTUP: begin
                // Conflict wins over the startup timeout.
                if (conflict) begin
                    state_d = ST_FAILSAFE;
                end else if (startup_cnt_q == SW'(STARTUP_CYCLES - 1)) begin
                    state_d = ST_NORMAL;
                end else begin
                    startup_cnt_d = startup_cnt_q + SW'(1);
                end
            end
            ST_NORMAL: begin
                if (conflict) state_d = ST_FAILSAFE;
            end
            ST_FAILSAFE: begin
                if (fault_clr && !conflict) state_d = ST_STARTUP;
            end
            default: state_d = ST_FAILSAFE;
        endcase

        // Lamps are chosen from the state being entered, so the edge that
        // enters FAILSAFE already loads fail-safe lamp values.
        h_car_lamp_d    = 4'b0001;
        v_car_lamp_d    = 4'b0001;
        h_walker_lamp_d = 2'b01;
        v_walker_lamp_d = 2'b01;
        fault_d         = 1'b0;
        case (state_d)
            ST_NORMAL: begin
                h_car_lamp_d    = car_decode(h_car_q);
                v_car_lamp_d    = car_decode(v_car_q);
                h_walker_lamp_d = walker_decode(h_walk_q, phase_d);
                v_walker_lamp_d = walker_decode(v_walk_q, phase_d);
            end
            ST_FAILSAFE: begin
                h_car_lamp_d = {2'b00, phase_d, 1'b0};
                v_car_lamp_d = {2'b00, phase_d, 1'b0};
                fault_d      = 1'b1;
            end
            default: ;
        endcase

`ifdef FAULT_COUNT_EN
        fault_count_d = fault_count;
        if ((state_q != ST_FAILSAFE) && (state_d == ST_FAILSAFE) && (fault_count != 8'hFF))
            fault_count_d = fault_count + 8'd1;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_STARTUP;
            startup_cnt_q <= '0;
            blink_cnt_q   <= '0;
            phase_q       <= 1'b1;
            h_car_q       <= CODE_RED;
            v_car_q       <= CODE_RED;
            h_walk_q      <= CODE_RED;
            v_walk_q      <= CODE_RED;
            h_car_lamp    <= 4'b0001;
            v_car_lamp    <= 4'b0001;
            h_walker_lamp <= 2'b01;
            v_walker_lamp <= 2'b01;
            fault         <= 1'b0;
`ifdef FAULT_COUNT_EN
            fault_count   <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            startup_cnt_q <= startup_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            phase_q       <= phase_d;
            h_car_q       <= h_car_code;
            v_car_q       <= v_car_code;
            h_walk_q      <= h_walker_code;
            v_walk_q      <= v_walker_code;
            h_car_lamp    <= h_car_lamp_d;
            v_car_lamp    <= v_car_lamp_d;
            h_walker_lamp <= h_walker_lamp_d;
            v_walker_lamp <= v_walker_lamp_d;
            fault         <= fault_d;
`ifdef FAULT_COUNT_EN
            fault_count   <= fault_count_d;
`endif
        end
    end

endmodule

// File: tb/tb_traffic_lamp_driver.sv
// ============================================================================
// tb_traffic_lamp_driver
// ----------------------------------------------------------------------------
// Directed bench for traffic_lamp_driver (BLINK_HALF=4, STARTUP_CYCLES=3).
// The stimulus process drives codes and pushes hand-computed expectations,
// tagged with the cycle number after reset release, into a queue. A monitor
// on the falling edge pops and compares every entry due in that cycle.
// ============================================================================
module tb_traffic_lamp_driver;

    localparam logic [2:0] C_RED = 3'b000, C_GRN = 3'b001, C_YEL = 3'b010, C_LEFT = 3'b011;
    localparam logic [2:0] W_RED = 3'b000, W_GRN = 3'b001, W_TWK = 3'b100;

    typedef struct packed {
        logic [31:0] tgt;
        logic [3:0]  hc;
        logic [3:0]  vc;
        logic [1:0]  hw;
        logic [1:0]  vw;
        logic        f;
        logic [7:0]  cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] h_car_code, v_car_code, h_walker_code, v_walker_code;
    logic       fault_clr;
    logic [3:0] h_car_lamp, v_car_lamp;
    logic [1:0] h_walker_lamp, v_walker_lamp;
    logic       fault;
`ifdef FAULT_COUNT_EN
    logic [7:0] fault_count;
`endif

    traffic_lamp_driver #(.BLINK_HALF(4), .STARTUP_CYCLES(3)) dut (
        .clk           (clk),
        .reset         (reset),
        .h_car_code    (h_car_code),
        .v_car_code    (v_car_code),
        .h_walker_code (h_walker_code),
        .v_walker_code (v_walker_code),
        .fault_clr     (fault_clr),
        .h_car_lamp    (h_car_lamp),
        .v_car_lamp    (v_car_lamp),
        .h_walker_lamp (h_walker_lamp),
        .v_walker_lamp (v_walker_lamp),
        .fault         (fault)
`ifdef FAULT_COUNT_EN
        ,
        .fault_count   (fault_count)
`endif
    );

    always #5 clk = ~clk;

    // Cycle index: 0 while in reset, N after the Nth edge following release.
    int cyc = 0;
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    exp_t  exp_q[$];
    string name_q[$];
    int    n_cmp  = 0;
    int    n_fail = 0;

    task automatic push(input int tgt, input logic [3:0] hc, input logic [3:0] vc,
                        input logic [1:0] hw, input logic [1:0] vw, input logic f,
                        input logic [7:0] cnt, input string name);
        exp_t e;
        e.tgt = tgt; e.hc = hc; e.vc = vc; e.hw = hw; e.vw = vw; e.f = f; e.cnt = cnt;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic set_codes(input logic [2:0] hc, input logic [2:0] vc,
                             input logic [2:0] hw, input logic [2:0] vw);
        h_car_code = hc; v_car_code = vc; h_walker_code = hw; v_walker_code = vw;
    endtask

    // Advance to 1 time unit after edge n of the current timeline.
    task automatic go_to(input int n);
        int guard = 0;
        while (cyc != n) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 200) begin
                $display("FAIL go_to: cycle %0d never reached, stuck at %0d", n, cyc);
                $fatal(1, "timeline lost");
            end
        end
    endtask

    // Monitor: outputs are presented every cycle; compare entries due now.
    exp_t  mon_e;
    string mon_n;
    logic  mon_bad;
    logic [7:0] mon_cnt;
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].tgt == cyc) begin
            mon_e = exp_q.pop_front();
            mon_n = name_q.pop_front();
            mon_bad = (h_car_lamp !== mon_e.hc) || (v_car_lamp !== mon_e.vc)
                   || (h_walker_lamp !== mon_e.hw) || (v_walker_lamp !== mon_e.vw)
                   || (fault !== mon_e.f);
`ifdef FAULT_COUNT_EN
            mon_cnt = fault_count;
            if (fault_count !== mon_e.cnt) mon_bad = 1'b1;
`else
            mon_cnt = 8'd0;
`endif
            n_cmp++;
            if (mon_bad) begin
                n_fail++;
                $display("FAIL %s (cycle %0d): got hc=%b vc=%b hw=%b vw=%b fault=%b cnt=%0d, want hc=%b vc=%b hw=%b vw=%b fault=%b cnt=%0d",
                         mon_n, cyc, h_car_lamp, v_car_lamp, h_walker_lamp, v_walker_lamp, fault, mon_cnt,
                         mon_e.hc, mon_e.vc, mon_e.hw, mon_e.vw, mon_e.f, mon_e.cnt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        fault_clr = 1'b0;
        set_codes(C_RED, C_RED, W_RED, W_RED);
        push(0, 4'b0001, 4'b0001, 2'b01, 2'b01, 1'b0, 8'd0, "reset_state");
        push(1, 4'b0001, 4'b0001, 2'b01, 2'b01, 1'b0, 8'd0, "startup_c1");
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Codes loaded during STARTUP appear exactly when NORMAL begins (edge 3).
        go_to(1);
        set_codes(C_GRN, C_RED, W_RED, W_GRN);
        push(2, 4'b0001, 4'b0001, 2'b01, 2'b01, 1'b0, 8'd0, "startup_c2");
        push(3, 4'b0100, 4'b0001, 2'b01, 2'b10, 1'b0, 8'd0, "normal_entry");

        // Left arrow, with the two-edge code-to-lamp latency.
        go_to(3);
        set_codes(C_LEFT, C_RED, W_RED, W_GRN);
        push(4, 4'b0100, 4'b0001, 2'b01, 2'b10, 1'b0, 8'd0, "left_latency");
        push(5, 4'b1001, 4'b0001, 2'b01, 2'b10, 1'b0, 8'd0, "left_arrow");

        // Twinkle: phase is 1 after edges 8..11 and 0 after edges 4..7, 12..15.
        go_to(5);
        set_codes(C_RED, C_GRN, W_TWK, W_RED);
        push(7,  4'b0001, 4'b0100, 2'b00, 2'b01, 1'b0, 8'd0, "twinkle_off7");
        push(8,  4'b0001, 4'b0100, 2'b10, 2'b01, 1'b0, 8'd0, "twinkle_on8");
        push(11, 4'b0001, 4'b0100, 2'b10, 2'b01, 1'b0, 8'd0, "twinkle_on11");
        push(12, 4'b0001, 4'b0100, 2'b00, 2'b01, 1'b0, 8'd0, "twinkle_off12");

        // One-cycle car conflict: lamps go straight from prior values to fail-safe.
        go_to(12);
        set_codes(C_GRN, C_YEL, W_RED, W_RED);
        push(13, 4'b0001, 4'b0100, 2'b00, 2'b01, 1'b0, 8'd0, "conflict_pre");
        push(14, 4'b0000, 4'b0000, 2'b01, 2'b01, 1'b1, 8'd1, "failsafe_entry");
        go_to(13);
        set_codes(C_RED, C_RED, W_RED, W_RED);
        push(16, 4'b0010, 4'b0010, 2'b01, 2'b01, 1'b1, 8'd1, "flash_on16");
        push(19, 4'b0010, 4'b0010, 2'b01, 2'b01, 1'b1, 8'd1, "flash_on19");
        push(20, 4'b0000, 4'b0000, 2'b01, 2'b01, 1'b1, 8'd1, "flash_off20");

        // fault_clr while a conflict sits in the code registers: stay.
        go_to(20);
        set_codes(C_GRN, C_GRN, W_RED, W_RED);
        go_to(21);
        fault_clr = 1'b1;
        push(22, 4'b0000, 4'b0000, 2'b01, 2'b01, 1'b1, 8'd1, "clr_with_conflict");
        go_to(22);
        fault_clr = 1'b0;
        set_codes(C_RED, C_RED, W_RED, W_RED);
        push(23, 4'b0000, 4'b0000, 2'b01, 2'b01, 1'b1, 8'd1, "held23");

        // fault_clr with legal codes: 3 all-red cycles, then NORMAL.
        go_to(24);
        fault_clr = 1'b1;
        push(25, 4'b0001, 4'b0001, 2'b01, 2'b01, 1'b0, 8'd1, "clr_exit");
        push(27, 4'b0001, 4'b0001, 2'b01, 2'b01, 1'b0, 8'd1, "restart_red27");
        push(28, 4'b0100, 4'b0001, 2'b01, 2'b01, 1'b0, 8'd1, "renormal28");
        go_to(25);
        fault_clr = 1'b0;
        set_codes(C_GRN, C_RED, W_RED, W_RED);

        // Illegal car code forces FAILSAFE; async reset mid-FAILSAFE.
        go_to(28);
        set_codes(3'b101, C_RED, W_RED, W_RED);
        push(29, 4'b0100, 4'b0001, 2'b01, 2'b01, 1'b0, 8'd1, "illegal_pre");
        push(30, 4'b0000, 4'b0000, 2'b01, 2'b01, 1'b1, 8'd2, "illegal_failsafe");
        push(31, 4'b0000, 4'b0000, 2'b01, 2'b01, 1'b1, 8'd2, "failsafe31");
        push(32, 4'b0001, 4'b0001, 2'b01, 2'b01, 1'b0, 8'd0, "async_reset");
        go_to(32);
        reset = 1'b1;
        set_codes(C_RED, C_RED, W_RED, W_RED);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        push(1, 4'b0001, 4'b0001, 2'b01, 2'b01, 1'b0, 8'd0, "post_reset1");
        push(2, 4'b0001, 4'b0001, 2'b01, 2'b01, 1'b0, 8'd0, "post_reset2");
        go_to(2);
        repeat (3) @(posedge clk);
        #1;

        if (exp_q.size() != 0) begin
            $display("FAIL leftover: %0d expectations never compared, required 0", exp_q.size());
            n_fail += exp_q.size();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
